// File: rtl/bnn_regs_pkg.sv
// Shared register map, bit indices and APB FSM states for the BNN control register file.
package bnn_regs_pkg;

    localparam logic [7:0] RegCtrl     = 8'h00;
    localparam logic [7:0] RegLastRow  = 8'h04;
    localparam logic [7:0] RegLastCol  = 8'h08;
    localparam logic [7:0] RegActAddr  = 8'h0C;
    localparam logic [7:0] RegBatch    = 8'h10;
    localparam logic [7:0] RegPsumAddr = 8'h14;
    localparam logic [7:0] RegAccum    = 8'h18;
    localparam logic [7:0] RegStatus   = 8'h1C;
    localparam logic [7:0] RegId       = 8'h20;

    localparam int unsigned CtrlWtBit     = 0;
    localparam int unsigned CtrlStartBit  = 1;
    localparam int unsigned StatusBusyBit = 0;
    localparam int unsigned StatusDoneBit = 1;
    localparam int unsigned StatusErrBit  = 2;

    typedef enum logic {
        StIdle,
        StAccess
    } apb_state_e;

endpackage

// File: rtl/bnn_sticky_bit.sv
// Sticky status flop: set by an event, cleared by write-1-to-clear; set wins when both occur.
module bnn_sticky_bit (
    input  logic clk,
    input  logic resetn,
    input  logic set_i,
    input  logic clr_i,
    output logic q_o
);

    logic q_d, q_q;

    always_comb begin
        q_d = set_i | (q_q & ~clr_i);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bnn_apb_ctrl_regs.sv
// APB3 control/status register file driving the BNN systolic array: config readback,
// sticky DONE/ERR status with irq, error responses, busy interlock and wait states.
module bnn_apb_ctrl_regs
    import bnn_regs_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ROW_W       = 5,
    parameter int unsigned COL_W       = 5,
    parameter int unsigned BUF_ADDR_W  = 11,
    parameter int unsigned BATCH_W     = 6,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] BLOCK_ID    = 32'hB77A_0002
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [ADDR_W-1:0]     s_apb_paddr,
    input  logic                  s_apb_psel,
    input  logic                  s_apb_penable,
    input  logic                  s_apb_pwrite,
    input  logic [31:0]           s_apb_pwdata,
    output logic                  s_apb_pready,
    output logic [31:0]           s_apb_prdata,
    output logic                  s_apb_pslverr,
    input  logic                  busy_i,
    input  logic                  done_i,
    output logic                  weight_transfer,
    output logic                  systolic_start,
    output logic [ROW_W-1:0]      last_row,
    output logic [COL_W-1:0]      last_col,
    output logic [BUF_ADDR_W-1:0] activations_addr_start,
    output logic [BUF_ADDR_W-1:0] partialsums_addr_start,
    output logic [BATCH_W-1:0]    batch,
    output logic                  accumulate,
    output logic                  irq
);

    apb_state_e state_d, state_q;
    logic [3:0] wait_cnt_d, wait_cnt_q;
    logic       pready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pready     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_apb_psel && !s_apb_penable) begin
                    wait_cnt_d = 4'(WAIT_STATES);
                    state_d    = StAccess;
                end
            end
            StAccess: begin
                // Dropping psel mid-access abandons the transfer without a commit.
                if (!s_apb_psel) begin
                    state_d = StIdle;
                end else if (s_apb_penable) begin
                    if (wait_cnt_q != 4'd0) begin
                        wait_cnt_d = wait_cnt_q - 4'd1;
                    end else begin
                        pready  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Address decode; bits [1:0] are ignored and anything past ID is out of range.
    logic [7:0] reg_off;
    logic       addr_hi_nz;
    logic       ctrl_busy_err;
    logic       xfer_err;
    logic       commit;

    assign reg_off       = {2'b00, s_apb_paddr[5:2], 2'b00};
    assign addr_hi_nz    = |s_apb_paddr[ADDR_W-1:6];
    assign ctrl_busy_err = s_apb_pwrite && (reg_off == RegCtrl) && busy_i &&
                           (s_apb_pwdata[CtrlWtBit] || s_apb_pwdata[CtrlStartBit]);
    assign xfer_err      = addr_hi_nz || (reg_off > RegId) ||
                           (s_apb_pwrite && (reg_off == RegId)) || ctrl_busy_err;
    assign commit        = pready && s_apb_pwrite && !xfer_err;

    logic [ROW_W-1:0]      last_row_q;
    logic [COL_W-1:0]      last_col_q;
    logic [BUF_ADDR_W-1:0] act_addr_q, psum_addr_q;
    logic [BATCH_W-1:0]    batch_q;
    logic                  accum_q, wt_pulse_q, start_pulse_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_row_q    <= '0;
            last_col_q    <= '0;
            act_addr_q    <= '0;
            psum_addr_q   <= '0;
            batch_q       <= '0;
            accum_q       <= 1'b0;
            wt_pulse_q    <= 1'b0;
            start_pulse_q <= 1'b0;
        end else begin
            wt_pulse_q    <= commit && (reg_off == RegCtrl) && s_apb_pwdata[CtrlWtBit];
            start_pulse_q <= commit && (reg_off == RegCtrl) && s_apb_pwdata[CtrlStartBit];
            if (commit) begin
                if (reg_off == RegLastRow)  last_row_q  <= s_apb_pwdata[ROW_W-1:0];
                if (reg_off == RegLastCol)  last_col_q  <= s_apb_pwdata[COL_W-1:0];
                if (reg_off == RegActAddr)  act_addr_q  <= s_apb_pwdata[BUF_ADDR_W-1:0];
                if (reg_off == RegBatch)    batch_q     <= s_apb_pwdata[BATCH_W-1:0];
                if (reg_off == RegPsumAddr) psum_addr_q <= s_apb_pwdata[BUF_ADDR_W-1:0];
                if (reg_off == RegAccum)    accum_q     <= s_apb_pwdata[0];
            end
        end
    end

    logic status_wr, done_q, err_q;
    assign status_wr = commit && (reg_off == RegStatus);

    bnn_sticky_bit u_done (
        .clk    (clk),
        .resetn (resetn),
        .set_i  (done_i),
        .clr_i  (status_wr && s_apb_pwdata[StatusDoneBit]),
        .q_o    (done_q)
    );

    bnn_sticky_bit u_err (
        .clk    (clk),
        .resetn (resetn),
        .set_i  (pready && xfer_err),
        .clr_i  (status_wr && s_apb_pwdata[StatusErrBit]),
        .q_o    (err_q)
    );

    logic [31:0] rdata;
    always_comb begin
        rdata = 32'h0;
        case (reg_off)
            RegLastRow:  rdata = 32'(last_row_q);
            RegLastCol:  rdata = 32'(last_col_q);
            RegActAddr:  rdata = 32'(act_addr_q);
            RegBatch:    rdata = 32'(batch_q);
            RegPsumAddr: rdata = 32'(psum_addr_q);
            RegAccum:    rdata = 32'(accum_q);
            RegStatus:   rdata = {29'h0, err_q, done_q, busy_i};
            RegId:       rdata = BLOCK_ID;
            default:     rdata = 32'h0;
        endcase
    end

    assign s_apb_pready  = pready;
    assign s_apb_pslverr = pready && xfer_err;
    assign s_apb_prdata  = (pready && !s_apb_pwrite && !xfer_err) ? rdata : 32'h0;

    assign weight_transfer        = wt_pulse_q;
    assign systolic_start         = start_pulse_q;
    assign last_row               = last_row_q;
    assign last_col               = last_col_q;
    assign activations_addr_start = act_addr_q;
    assign partialsums_addr_start = psum_addr_q;
    assign batch                  = batch_q;
    assign accumulate             = accum_q;
    assign irq                    = done_q;

    logic unused_ok;
    assign unused_ok = ^{s_apb_paddr[1:0], s_apb_pwdata};

endmodule
